// File: rtl/cache_tag_ctrl.sv
// Tag lookup and miss-handling controller for a 4-way set-associative cache.
// Serves one CPU request at a time: hit check, victim choice, writeback, refill, install.
module cache_tag_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cpu_req_valid,
    output logic                cpu_req_ready,
    input  logic [ADDR_W-1:0]   cpu_req_addr,
    input  logic                cpu_req_we,
    output logic                cpu_resp_valid,
    output logic                cpu_resp_hit,
    output logic [1:0]          cpu_resp_way,
    output logic                lru_update_en,
    output logic [INDEX_W-1:0]  lru_set_idx,
    output logic [1:0]          lru_accessed_way,
    output logic [INDEX_W-1:0]  lru_query_idx,
    input  logic [1:0]          lru_victim_way,
    output logic                mem_req_valid,
    output logic                mem_req_we,
    output logic [ADDR_W-1:0]   mem_req_addr,
    input  logic                mem_ack,
    output logic [2:0]          state_dbg
);

    // Handshakes: a CPU request transfers on a cycle with cpu_req_valid & cpu_req_ready;
    // a memory request is held with stable fields until the cycle mem_ack is high.

    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int NUM_SETS = 1 << INDEX_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOOKUP  = 3'd1,
        S_VICTIM  = 3'd2,
        S_WB      = 3'd3,
        S_REFILL  = 3'd4,
        S_INSTALL = 3'd5,
        S_RESP    = 3'd6
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [ADDR_W-1:0]              req_addr_q;
    logic                           req_we_q;
    logic [1:0]                     sel_q;
    logic                           resp_hit_q;
    logic [1:0]                     resp_way_q;
    logic                           ready_en_q;

    logic [NUM_SETS-1:0][3:0]       valid_q;
    logic [NUM_SETS-1:0][3:0]       dirty_q;
    logic [TAG_W-1:0]               tag_q [NUM_SETS][4];

    logic [TAG_W-1:0]               req_tag;
    logic [INDEX_W-1:0]             req_idx;
    logic                           hit;
    logic [1:0]                     hit_way;
    logic                           inv_found;
    logic [1:0]                     inv_way;
    logic [1:0]                     victim_sel;
    logic                           accept;

    assign req_tag   = req_addr_q[ADDR_W-1 -: TAG_W];
    assign req_idx   = req_addr_q[OFFSET_W +: INDEX_W];
    assign accept    = (state_q == S_IDLE) && cpu_req_valid && ready_en_q;
    assign state_dbg = state_q;

    // Descending scan so the lowest matching way is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_way = 2'd0;
        for (int w = 3; w >= 0; w--) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = 2'(w);
            end
        end
    end

    always_comb begin
        inv_found = 1'b0;
        inv_way   = 2'd0;
        for (int w = 3; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = 2'(w);
            end
        end
        victim_sel = inv_found ? inv_way : lru_victim_way;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cpu_req_ready    = 1'b0;
        cpu_resp_valid   = 1'b0;
        cpu_resp_hit     = 1'b0;
        cpu_resp_way     = 2'd0;
        lru_update_en    = 1'b0;
        lru_set_idx      = '0;
        lru_accessed_way = 2'd0;
        mem_req_valid    = 1'b0;
        mem_req_we       = 1'b0;
        mem_req_addr     = '0;
        case (state_q)
            S_IDLE: begin
                cpu_req_ready = ready_en_q;
                if (accept) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (hit) begin
                    lru_update_en    = 1'b1;
                    lru_set_idx      = req_idx;
                    lru_accessed_way = hit_way;
                    state_d          = S_RESP;
                end else begin
                    state_d = S_VICTIM;
                end
            end
            S_VICTIM: begin
                if (valid_q[req_idx][victim_sel] && dirty_q[req_idx][victim_sel])
                    state_d = S_WB;
                else
                    state_d = S_REFILL;
            end
            S_WB: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {tag_q[req_idx][sel_q], req_idx, {OFFSET_W{1'b0}}};
                if (mem_ack) state_d = S_REFILL;
            end
            S_REFILL: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_tag, req_idx, {OFFSET_W{1'b0}}};
                if (mem_ack) state_d = S_INSTALL;
            end
            S_INSTALL: begin
                lru_update_en    = 1'b1;
                lru_set_idx      = req_idx;
                lru_accessed_way = sel_q;
                state_d          = S_RESP;
            end
            S_RESP: begin
                cpu_resp_valid = 1'b1;
                cpu_resp_hit   = resp_hit_q;
                cpu_resp_way   = resp_way_q;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ready_en_q keeps cpu_req_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_en_q    <= 1'b0;
            req_addr_q    <= '0;
            req_we_q      <= 1'b0;
            lru_query_idx <= '0;
            sel_q         <= 2'd0;
            resp_hit_q    <= 1'b0;
            resp_way_q    <= 2'd0;
            valid_q       <= '0;
            dirty_q       <= '0;
        end else begin
            ready_en_q <= 1'b1;
            if (accept) begin
                req_addr_q    <= cpu_req_addr;
                req_we_q      <= cpu_req_we;
                lru_query_idx <= cpu_req_addr[OFFSET_W +: INDEX_W];
            end
            if ((state_q == S_LOOKUP) && hit) begin
                resp_hit_q <= 1'b1;
                resp_way_q <= hit_way;
                if (req_we_q) dirty_q[req_idx][hit_way] <= 1'b1;
            end
            if (state_q == S_VICTIM) sel_q <= victim_sel;
            if (state_q == S_INSTALL) begin
                valid_q[req_idx][sel_q] <= 1'b1;
                dirty_q[req_idx][sel_q] <= req_we_q;
                resp_hit_q              <= 1'b0;
                resp_way_q              <= sel_q;
            end
        end
    end

    // Tags carry no reset; they are only meaningful alongside a set valid bit.
    always_ff @(posedge clk) begin
        if (state_q == S_INSTALL) tag_q[req_idx][sel_q] <= req_tag;
    end

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Directed bench for cache_tag_ctrl: per-scenario tasks with inline checks and a
// bench-side memory responder; the LRU victim input is driven directly by each test.
module tb_cache_tag_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req_valid = 1'b0;
    logic        cpu_req_ready;
    logic [31:0] cpu_req_addr = '0;
    logic        cpu_req_we = 1'b0;
    logic        cpu_resp_valid;
    logic        cpu_resp_hit;
    logic [1:0]  cpu_resp_way;
    logic        lru_update_en;
    logic [5:0]  lru_set_idx;
    logic [1:0]  lru_accessed_way;
    logic [5:0]  lru_query_idx;
    logic [1:0]  lru_victim_way = 2'd0;
    logic        mem_req_valid;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic        mem_ack = 1'b0;
    logic [2:0]  state_dbg;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        hit;
        logic [1:0]  way;
        int          lat;
        int          lru_cnt;
        logic [5:0]  lru_set;
        logic [1:0]  lru_way;
        int          n_wb;
        logic [31:0] wb_addr;
        int          n_rd;
        logic [31:0] rd_addr;
        int          unstable;
        int          rdy_bad;
        logic        timeout;
    } obs_t;

    always #5 clk = ~clk;

    cache_tag_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_addr(cpu_req_addr), .cpu_req_we(cpu_req_we),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_hit(cpu_resp_hit), .cpu_resp_way(cpu_resp_way),
        .lru_update_en(lru_update_en), .lru_set_idx(lru_set_idx),
        .lru_accessed_way(lru_accessed_way), .lru_query_idx(lru_query_idx),
        .lru_victim_way(lru_victim_way),
        .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_ack(mem_ack), .state_dbg(state_dbg)
    );

    // Driver: issues one request, answers memory after ack_delay wait cycles, observes to response.
    task automatic run_req(input logic [31:0] addr, input logic we, input int ack_delay, output obs_t o);
        int          cyc;
        int          wcnt;
        logic        in_req;
        logic        cur_we;
        logic [31:0] cur_addr;
        logic        done;
        o = '{hit: 1'b0, way: 2'd0, lat: 0, lru_cnt: 0, lru_set: 6'd0, lru_way: 2'd0,
              n_wb: 0, wb_addr: 32'd0, n_rd: 0, rd_addr: 32'd0, unstable: 0, rdy_bad: 0,
              timeout: 1'b0};
        in_req = 1'b0; wcnt = 0; cur_we = 1'b0; cur_addr = '0; done = 1'b0;
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_addr = addr; cpu_req_we = we;
        cyc = 0;
        while (!cpu_req_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!cpu_req_ready) begin
            o.timeout = 1'b1;
            cpu_req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        cpu_req_valid = 1'b0; cpu_req_addr = '0; cpu_req_we = 1'b0;
        o.lat = 1;
        while (!done && o.lat < 200) begin
            mem_ack = 1'b0;
            if (lru_update_en) begin
                o.lru_cnt++;
                o.lru_set = lru_set_idx;
                o.lru_way = lru_accessed_way;
            end
            if (mem_req_valid) begin
                if (!in_req) begin
                    in_req = 1'b1; wcnt = 0; cur_we = mem_req_we; cur_addr = mem_req_addr;
                    if (mem_req_we) begin o.n_wb++; o.wb_addr = mem_req_addr; end
                    else begin o.n_rd++; o.rd_addr = mem_req_addr; end
                end else if (mem_req_we !== cur_we || mem_req_addr !== cur_addr) begin
                    o.unstable++;
                end
                if (cpu_req_ready) o.rdy_bad++;
                if (wcnt == ack_delay) begin
                    mem_ack = 1'b1;
                    in_req  = 1'b0;
                end else begin
                    wcnt++;
                end
            end
            if (cpu_resp_valid) begin
                o.hit = cpu_resp_hit;
                o.way = cpu_resp_way;
                done  = 1'b1;
            end else begin
                @(negedge clk);
                o.lat++;
            end
        end
        mem_ack = 1'b0;
        if (!done) o.timeout = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (cpu_req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b exp=0", cpu_req_ready); end
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_mem_valid got=%0b exp=0", mem_req_valid); end
        total++; if (cpu_resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%0b exp=0", cpu_resp_valid); end
        total++; if (lru_update_en !== 1'b0) begin bad++; $display("FAIL rst_lru_en got=%0b exp=0", lru_update_en); end
        total++; if (lru_query_idx !== 6'd0) begin bad++; $display("FAIL rst_query_idx got=%0h exp=0", lru_query_idx); end
        total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state_dbg); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (cpu_req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after got=%0b exp=1", cpu_req_ready); end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        total++; if (cpu_req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
            bad++; $display("FAIL idle_ack_ignored ready=%0b mem_valid=%0b exp ready=1 mem_valid=0", cpu_req_ready, mem_req_valid);
        end
    endtask

    task automatic test_cold_miss();
        obs_t o;
        lru_victim_way = 2'd3;
        run_req(32'h0000_1230, 1'b0, 0, o);
        total++; if (o.timeout !== 1'b0) begin bad++; $display("FAIL t1_timeout got=1 exp=0"); end
        total++; if (o.hit !== 1'b0 || o.way !== 2'd0) begin bad++; $display("FAIL t1_resp got hit=%0b way=%0d exp hit=0 way=0", o.hit, o.way); end
        total++; if (o.n_rd !== 1 || o.rd_addr !== 32'h0000_1230 || o.n_wb !== 0) begin
            bad++; $display("FAIL t1_mem got rd=%0d addr=%h wb=%0d exp rd=1 addr=00001230 wb=0", o.n_rd, o.rd_addr, o.n_wb);
        end
        total++; if (o.lru_cnt !== 1 || o.lru_set !== 6'h23 || o.lru_way !== 2'd0) begin
            bad++; $display("FAIL t1_lru got cnt=%0d set=%h way=%0d exp cnt=1 set=23 way=0", o.lru_cnt, o.lru_set, o.lru_way);
        end
        total++; if (lru_query_idx !== 6'h23) begin bad++; $display("FAIL t1_query_idx got=%h exp=23", lru_query_idx); end
    endtask

    task automatic test_hit();
        obs_t o;
        run_req(32'h0000_1234, 1'b0, 0, o);
        total++; if (o.hit !== 1'b1 || o.way !== 2'd0) begin bad++; $display("FAIL t2_resp got hit=%0b way=%0d exp hit=1 way=0", o.hit, o.way); end
        total++; if (o.lat !== 2) begin bad++; $display("FAIL t2_latency got=%0d exp=2", o.lat); end
        total++; if (o.lru_cnt !== 1 || o.lru_set !== 6'h23 || o.lru_way !== 2'd0) begin
            bad++; $display("FAIL t2_lru got cnt=%0d set=%h way=%0d exp cnt=1 set=23 way=0", o.lru_cnt, o.lru_set, o.lru_way);
        end
        total++; if (o.n_rd !== 0 || o.n_wb !== 0) begin bad++; $display("FAIL t2_no_mem got rd=%0d wb=%0d exp 0 0", o.n_rd, o.n_wb); end
    endtask

    task automatic test_fill_and_evict();
        obs_t o;
        logic [31:0] fill_addr [3];
        fill_addr[0] = 32'h0000_1630;
        fill_addr[1] = 32'h0000_1A30;
        fill_addr[2] = 32'h0000_1E30;
        lru_victim_way = 2'd0;
        for (int i = 0; i < 3; i++) begin
            run_req(fill_addr[i], 1'b0, 1, o);
            total++; if (o.hit !== 1'b0 || o.way !== 2'(i + 1)) begin
                bad++; $display("FAIL t3_fill%0d got hit=%0b way=%0d exp hit=0 way=%0d", i, o.hit, o.way, i + 1);
            end
        end
        run_req(32'h0000_1230, 1'b0, 0, o);
        total++; if (o.hit !== 1'b1 || o.way !== 2'd0) begin bad++; $display("FAIL t3_rehit got hit=%0b way=%0d exp hit=1 way=0", o.hit, o.way); end
        lru_victim_way = 2'd1;
        run_req(32'h0000_2230, 1'b0, 0, o);
        total++; if (o.hit !== 1'b0 || o.way !== 2'd1) begin bad++; $display("FAIL t3_evict got hit=%0b way=%0d exp hit=0 way=1", o.hit, o.way); end
        total++; if (o.n_wb !== 0 || o.n_rd !== 1 || o.rd_addr !== 32'h0000_2230) begin
            bad++; $display("FAIL t3_mem got wb=%0d rd=%0d addr=%h exp wb=0 rd=1 addr=00002230", o.n_wb, o.n_rd, o.rd_addr);
        end
        total++; if (o.lru_cnt !== 1 || o.lru_way !== 2'd1) begin bad++; $display("FAIL t3_lru got cnt=%0d way=%0d exp cnt=1 way=1", o.lru_cnt, o.lru_way); end
    endtask

    task automatic test_writeback();
        obs_t o;
        run_req(32'h0000_2238, 1'b1, 0, o);
        total++; if (o.hit !== 1'b1 || o.way !== 2'd1) begin bad++; $display("FAIL t4_store got hit=%0b way=%0d exp hit=1 way=1", o.hit, o.way); end
        lru_victim_way = 2'd1;
        run_req(32'h0000_2630, 1'b0, 2, o);
        total++; if (o.n_wb !== 1 || o.wb_addr !== 32'h0000_2230) begin
            bad++; $display("FAIL t4_wb got n=%0d addr=%h exp n=1 addr=00002230", o.n_wb, o.wb_addr);
        end
        total++; if (o.n_rd !== 1 || o.rd_addr !== 32'h0000_2630) begin
            bad++; $display("FAIL t4_refill got n=%0d addr=%h exp n=1 addr=00002630", o.n_rd, o.rd_addr);
        end
        total++; if (o.hit !== 1'b0 || o.way !== 2'd1 || o.lru_cnt !== 1) begin
            bad++; $display("FAIL t4_resp got hit=%0b way=%0d lru=%0d exp hit=0 way=1 lru=1", o.hit, o.way, o.lru_cnt);
        end
        run_req(32'h0000_2A30, 1'b0, 0, o);
        total++; if (o.n_wb !== 0 || o.rd_addr !== 32'h0000_2A30 || o.way !== 2'd1) begin
            bad++; $display("FAIL t4_clean_after_load got wb=%0d addr=%h way=%0d exp wb=0 addr=00002a30 way=1", o.n_wb, o.rd_addr, o.way);
        end
    endtask

    task automatic test_slow_refill();
        obs_t o;
        lru_victim_way = 2'd2;
        run_req(32'h0000_2E30, 1'b0, 20, o);
        total++; if (o.unstable !== 0) begin bad++; $display("FAIL t5_stable got=%0d exp=0", o.unstable); end
        total++; if (o.rdy_bad !== 0) begin bad++; $display("FAIL t5_ready_low got=%0d exp=0", o.rdy_bad); end
        total++; if (o.n_rd !== 1 || o.n_wb !== 0 || o.way !== 2'd2 || o.timeout !== 1'b0) begin
            bad++; $display("FAIL t5_resp got rd=%0d wb=%0d way=%0d to=%0b exp rd=1 wb=0 way=2 to=0", o.n_rd, o.n_wb, o.way, o.timeout);
        end
    endtask

    task automatic test_reset_in_wb();
        obs_t o;
        int   cyc;
        run_req(32'h0000_2E30, 1'b1, 0, o);
        total++; if (o.hit !== 1'b1 || o.way !== 2'd2) begin bad++; $display("FAIL t6_store got hit=%0b way=%0d exp hit=1 way=2", o.hit, o.way); end
        lru_victim_way = 2'd2;
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_addr = 32'h0000_3230; cpu_req_we = 1'b0;
        cyc = 0;
        while (!cpu_req_ready && cyc < 20) begin @(negedge clk); cyc++; end
        @(negedge clk);
        cpu_req_valid = 1'b0;
        cyc = 0;
        while (!(mem_req_valid && mem_req_we) && cyc < 20) begin @(negedge clk); cyc++; end
        total++; if (!(mem_req_valid && mem_req_we) || mem_req_addr !== 32'h0000_2E30) begin
            bad++; $display("FAIL t6_wb_reached got valid=%0b we=%0b addr=%h exp 1 1 00002e30", mem_req_valid, mem_req_we, mem_req_addr);
        end
        #2 reset_n = 1'b0;
        #1;
        total++; if (mem_req_valid !== 1'b0 || cpu_req_ready !== 1'b0) begin
            bad++; $display("FAIL t6_async_drop got mem_valid=%0b ready=%0b exp 0 0", mem_req_valid, cpu_req_ready);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        lru_victim_way = 2'd3;
        run_req(32'h0000_1230, 1'b0, 0, o);
        total++; if (o.hit !== 1'b0 || o.way !== 2'd0 || o.n_wb !== 0) begin
            bad++; $display("FAIL t6_miss_a got hit=%0b way=%0d wb=%0d exp hit=0 way=0 wb=0", o.hit, o.way, o.n_wb);
        end
        run_req(32'h0000_2E30, 1'b0, 0, o);
        total++; if (o.hit !== 1'b0 || o.way !== 2'd1 || o.n_wb !== 0) begin
            bad++; $display("FAIL t6_miss_b got hit=%0b way=%0d wb=%0d exp hit=0 way=1 wb=0", o.hit, o.way, o.n_wb);
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_fill_and_evict();
        test_writeback();
        test_slow_refill();
        test_reset_in_wb();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
